input_debouncer: RTL and testbench
==================================

# input_debouncer

Multi-channel synchronizer and debouncer for raw push-button/switch pins on the Mojo board. It sits directly upstream of the combinational gate logic: the external `A`/`B` pins enter here, and its `clean_out` bits drive the gate inputs in place of the raw pins. Each channel passes through a two-flop synchronizer and a stability counter. Per-channel rise/fall strobes and a toggle latch are provided for LED and demo logic.

## Interface
- `WIDTH`, 2: number of independent input channels.
- `STABLE_CYCLES`, 1000000: consecutive cycles a synchronized input must differ from `clean_out` before `clean_out` follows it. At 50 MHz, 1000000 cycles is 20 ms. Legal range is at least 1. Benches override it to a small value.
- `clk`  input  1  50 MHz system clock; all state on its rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low; clears all state immediately.
- `raw_in`  input  WIDTH  asynchronous raw pin levels; bit i is channel i.
- `clean_out`  output  WIDTH  debounced, synchronized level per channel.
- `rise_pulse`  output  WIDTH  one-cycle strobe when `clean_out[i]` goes 0→1.
- `fall_pulse`  output  WIDTH  one-cycle strobe when `clean_out[i]` goes 1→0.
- `toggle_out`  output  WIDTH  inverts on every `rise_pulse[i]`.

## Operation
- Per-channel pipeline: `raw_in[i]` → `sync1[i]` → `sync2[i]`. Only `sync2` feeds the debounce logic; `raw_in` is never used combinationally.
- Per-channel counter `cnt[i]`, width `$clog2(STABLE_CYCLES+1)`. Conceptually each channel is a two-state FSM:
  - **STABLE**: `sync2 == clean_out`. `cnt` is held at 0.
  - **PENDING**: `sync2 != clean_out`.
- On each edge in PENDING:
  - If `cnt == STABLE_CYCLES-1`: `clean_out[i] <= sync2[i]`, `cnt <= 0`, and the matching strobe is set for the next cycle.
  - Otherwise: `cnt <= cnt + 1`.
- Any edge where `sync2 == clean_out` (a glitch returning to the old level) clears `cnt` to 0 with no output change. Partial counts are never retained.
- The counter cannot overflow: it only counts up to `STABLE_CYCLES-1` and then clears.
- Strobes:
  - `rise_pulse`/`fall_pulse` are registered and asserted in exactly the cycle in which the new `clean_out` value first appears.
  - They are high for one cycle only, and are never both high on the same channel.
- `toggle_out[i]` updates on the same edge as `clean_out[i]`, for rising transitions only.
- Channels are fully independent. Simultaneous transitions on several channels each produce their own strobes in the same cycle.
- `STABLE_CYCLES == 1`: `clean_out` follows `sync2` one edge after `sync2` changes. In this mode the block acts as a pure synchronizer plus edge detector.

## Timing
- Reset (`rst_n` low, asynchronous): `sync1`, `sync2`, `cnt`, `clean_out`, `rise_pulse`, `fall_pulse` and `toggle_out` all go to 0 immediately.
  - Reset asserted mid-count discards the count.
  - Release is sampled synchronously; no output moves on the release edge itself.
- Latency: number edges from the first edge that samples a new `raw_in` level (edge 1).
  - Given the level holds, `clean_out` and the strobe change after edge `STABLE_CYCLES+2`.
  - Example: with `STABLE_CYCLES = 4`, the change appears after edge 6.
- Input held high through reset release: the channel debounces from `clean_out = 0` and produces one `rise_pulse` `STABLE_CYCLES+2` edges after the first post-reset edge.
- Minimum spacing between strobes on one channel is `STABLE_CYCLES` cycles.
- Throughput: one update per channel per cycle. There is no handshake and no backpressure; consumers must sample the strobes every cycle.

## Test plan
All scenarios use `WIDTH = 2` and `STABLE_CYCLES = 4`.
1. **Reset values.** Drive `rst_n = 0` mid-simulation with `raw_in = 2'b11` → all outputs are 0 asynchronously, before the next clock edge. They stay 0 while reset is held.
2. **Clean press.** `raw_in[0]` goes 0→1 and holds → `clean_out[0]` becomes 1 and `rise_pulse[0]` is high for exactly one cycle, both after edge 6. `toggle_out[0]` = 1 and channel 1 is unchanged.
3. **Bounce rejection.** `raw_in[0]` toggles 1,0,1,0 with a new value every 3 cycles, then holds 1.
   - No strobe appears during the bouncing.
   - After the final hold, a single `rise_pulse[0]` fires 6 edges after the last 0→1 edge.
   - Then release to 0 → `fall_pulse[0]` fires once and `toggle_out[0]` stays 1.
4. **Simultaneous channels.** `raw_in` goes 00→11 on one edge → after edge 6, `rise_pulse = 2'b11` in the same cycle and `clean_out = 2'b11`.
   - Then `raw_in = 01` → `fall_pulse = 2'b10` only.
5. **Reset mid-count.** `raw_in[1]` goes high, then `rst_n` is pulsed low at edge 4 while `raw_in` keeps its value.
   - No strobe is produced before the reset.
   - After release, `rise_pulse[1]` fires 6 edges after the first post-reset edge.
6. **Toggle latch.** Three clean press/release cycles on channel 0 → `toggle_out[0]` sequence is 1, 0, 1. Exactly 3 rise pulses and 3 fall pulses are counted.

Source files
------------

// File: rtl/input_debouncer.sv
// Multi-channel two-flop synchronizer and stability-counter debouncer.
// Each channel produces a clean level, registered rise/fall strobes and a toggle latch.

module input_debouncer_lane #(
    parameter int STABLE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall,
    output logic toggle
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } state_t;

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             clean_nxt;
    logic             rise_nxt;
    logic             fall_nxt;
    logic             toggle_nxt;
    state_t           state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            cnt    <= '0;
            clean  <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
            toggle <= 1'b0;
        end else begin
            sync1  <= raw;
            sync2  <= sync1;
            cnt    <= cnt_nxt;
            clean  <= clean_nxt;
            rise   <= rise_nxt;
            fall   <= fall_nxt;
            toggle <= toggle_nxt;
        end
    end

    // The state is implied by the synchronized level versus the committed level;
    // leaving PENDING for any reason drops the partial count.
    always_comb begin
        state      = (sync2 != clean) ? PENDING : STABLE;
        cnt_nxt    = '0;
        clean_nxt  = clean;
        rise_nxt   = 1'b0;
        fall_nxt   = 1'b0;
        toggle_nxt = toggle;
        case (state)
            STABLE: begin
                cnt_nxt = '0;
            end
            PENDING: begin
                if (cnt == CNT_LAST) begin
                    clean_nxt  = sync2;
                    rise_nxt   = sync2;
                    fall_nxt   = ~sync2;
                    toggle_nxt = toggle ^ sync2;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                cnt_nxt = '0;
            end
        endcase
    end

endmodule

module input_debouncer #(
    parameter int WIDTH         = 2,
    parameter int STABLE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] clean_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic [WIDTH-1:0] toggle_out
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        input_debouncer_lane #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .raw    (raw_in[i]),
            .clean  (clean_out[i]),
            .rise   (rise_pulse[i]),
            .fall   (fall_pulse[i]),
            .toggle (toggle_out[i])
        );
    end

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer: a window-based reference model checked every
// cycle, plus literal expectations at the key edges of each scenario.

module tb_input_debouncer;

    localparam int W = 2;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] raw_in;
    logic [W-1:0] clean_out, rise_pulse, fall_pulse, toggle_out;

    int checks   = 0;
    int failures = 0;
    int rise_cnt0 = 0;
    int fall_cnt0 = 0;

    input_debouncer #(.WIDTH(W), .STABLE_CYCLES(S)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw_in     (raw_in),
        .clean_out  (clean_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .toggle_out (toggle_out)
    );

    always #5 clk = ~clk;

    // Reference: raw level sampled at edge k reaches the debounce logic at edge k+2.
    // The output flips at edge n when the S most recent edges, all after the last
    // flip, saw a delayed level different from the committed one.
    bit           hist [W][$];
    int           edge_no = 0;
    int           last_flip [W] = '{0, 0};
    logic [W-1:0] m_clean = '0, m_rise = '0, m_fall = '0, m_tog = '0;

    function automatic bit delayed(int ch, int k);
        if (k - 2 >= 1) return hist[ch][k-3];
        return 1'b0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < W; c++) begin
                hist[c].delete();
                last_flip[c] = 0;
            end
            edge_no = 0;
            m_clean = '0; m_rise = '0; m_fall = '0; m_tog = '0;
        end else begin
            edge_no++;
            for (int c = 0; c < W; c++) begin
                bit flip;
                hist[c].push_back(raw_in[c]);
                m_rise[c] = 1'b0;
                m_fall[c] = 1'b0;
                flip = (edge_no - S + 1) > last_flip[c];
                for (int k = edge_no - S + 1; k <= edge_no; k++)
                    if (flip && delayed(c, k) == m_clean[c]) flip = 1'b0;
                if (flip) begin
                    m_clean[c]   = ~m_clean[c];
                    m_rise[c]    = m_clean[c];
                    m_fall[c]    = ~m_clean[c];
                    m_tog[c]     = m_tog[c] ^ m_clean[c];
                    last_flip[c] = edge_no;
                end
            end
        end
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_clean", clean_out, m_clean);
        check("model_rise", rise_pulse, m_rise);
        check("model_fall", fall_pulse, m_fall);
        check("model_toggle", toggle_out, m_tog);
        if (rst_n && rise_pulse[0] === 1'b1) rise_cnt0++;
        if (rst_n && fall_pulse[0] === 1'b1) fall_cnt0++;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        raw_in = '0;
        step(3);
        rst_n = 1'b1;
    endtask

    logic [W-1:0] tog_exp [3] = '{2'b01, 2'b00, 2'b01};

    initial begin
        rst_n  = 1'b0;
        raw_in = '0;
        do_reset();

        // 1: asynchronous reset with inputs high
        raw_in = 2'b11;
        step(7);
        check("pre_reset_clean", clean_out, 2'b11);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_clean", clean_out, 2'b00);
        check("async_rst_toggle", toggle_out, 2'b00);
        check("async_rst_strobes", rise_pulse | fall_pulse, 2'b00);
        step(3);
        check("held_rst_clean", clean_out, 2'b00);
        check("held_rst_toggle", toggle_out, 2'b00);

        // 2: clean press on channel 0
        do_reset();
        raw_in = 2'b01;
        step(5);
        check("press_edge5_clean", clean_out, 2'b00);
        check("press_edge5_rise", rise_pulse, 2'b00);
        step(1);
        check("press_edge6_clean", clean_out, 2'b01);
        check("press_edge6_rise", rise_pulse, 2'b01);
        check("press_edge6_toggle", toggle_out, 2'b01);
        step(1);
        check("press_edge7_rise", rise_pulse, 2'b00);

        // 3: bounce rejection
        do_reset();
        rise_cnt0 = 0;
        fall_cnt0 = 0;
        for (int i = 0; i < 4; i++) begin
            raw_in = (i % 2 == 0) ? 2'b01 : 2'b00;
            step(3);
        end
        raw_in = 2'b01;
        checks++;
        if (rise_cnt0 != 0 || fall_cnt0 != 0) begin
            failures++;
            $display("FAIL bounce_no_strobe: got rise=%0d fall=%0d expected 0 0", rise_cnt0, fall_cnt0);
        end
        step(5);
        check("bounce_edge5_rise", rise_pulse, 2'b00);
        step(1);
        check("bounce_edge6_rise", rise_pulse, 2'b01);
        raw_in = 2'b00;
        step(6);
        check("bounce_release_fall", fall_pulse, 2'b01);
        check("bounce_release_toggle", toggle_out, 2'b01);
        step(1);
        checks++;
        if (rise_cnt0 != 1 || fall_cnt0 != 1) begin
            failures++;
            $display("FAIL bounce_counts: got rise=%0d fall=%0d expected 1 1", rise_cnt0, fall_cnt0);
        end

        // 4: simultaneous channels
        do_reset();
        raw_in = 2'b11;
        step(6);
        check("simul_rise", rise_pulse, 2'b11);
        check("simul_clean", clean_out, 2'b11);
        raw_in = 2'b01;
        step(6);
        check("simul_fall", fall_pulse, 2'b10);
        check("simul_fall_rise", rise_pulse, 2'b00);
        check("simul_fall_clean", clean_out, 2'b01);

        // 5: reset mid-count
        do_reset();
        raw_in = 2'b10;
        step(3);
        check("midcount_pre_rise", rise_pulse, 2'b00);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midcount_rst_clean", clean_out, 2'b00);
        step(1);
        rst_n = 1'b1;
        step(5);
        check("midcount_edge5_rise", rise_pulse, 2'b00);
        step(1);
        check("midcount_edge6_rise", rise_pulse, 2'b10);
        check("midcount_edge6_clean", clean_out, 2'b10);

        // 6: toggle latch over three press/release cycles
        do_reset();
        rise_cnt0 = 0;
        fall_cnt0 = 0;
        for (int i = 0; i < 3; i++) begin
            raw_in = 2'b01;
            step(8);
            check("toggle_seq", toggle_out, tog_exp[i]);
            raw_in = 2'b00;
            step(8);
        end
        checks++;
        if (rise_cnt0 != 3 || fall_cnt0 != 3) begin
            failures++;
            $display("FAIL toggle_counts: got rise=%0d fall=%0d expected 3 3", rise_cnt0, fall_cnt0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
